rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 2, entries per source queue (power of two, 2..8).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: alu_valid input 1, alu_addr input 5, alu_data input 32, alu_ready output 1  ALU writeback request.
REQ-005 SHALL have ports: mem_valid input 1, mem_addr input 5, mem_data input 32, mem_ready output 1  load-unit writeback request.
REQ-006 SHALL have ports: write_en output 1, write_addr output 5, write_data output 32  register-file write port; all registered.
REQ-007 SHALL have port: pending_mask  output  32  bit i = write to Ri queued or being issued.

Function
REQ-008 SHALL accept a source request in a cycle where valid and ready are both high (handshake).
REQ-009 SHALL drive src_ready = 1 iff that source's queue is not full; a same-cycle pop SHALL NOT raise ready when full.
REQ-010 SHALL keep one FIFO per source and preserve order within a source; no ordering between sources.
REQ-011 SHALL consume handshakes with addr = 0 without enqueueing; write_en never asserted for R0.
REQ-012 SHALL grant at most one non-empty queue head per cycle, round-robin; grant pointer toggles only on a grant.
REQ-013 SHALL, with both heads present, grant the source not granted last; after reset ALU wins first tie.
REQ-014 SHALL register the granted head into write_en/write_addr/write_data for exactly one cycle per entry.
REQ-015 SHALL issue an uncontended handshake in cycle T with write_en high in cycle T+2.
REQ-016 SHALL drive write_en = 0 when no grant; write_addr/write_data SHALL hold last issued values.
REQ-017 SHALL sustain one write per cycle while any queue is non-empty (no bubbles).
REQ-018 SHALL allow push and pop of the same queue in one cycle when not full; count unchanged.
REQ-019 SHALL wrap queue read/write pointers modulo FIFO_DEPTH.
REQ-020 SHALL never drop or duplicate an accepted non-R0 request (outside reset).

Reset
REQ-021 SHALL, on rst high at a rising edge, empty both queues, discard queued writes, clear grant pointer to ALU-preferred.
REQ-022 SHALL drive after reset: write_en 0, write_addr 0, write_data 0, pending_mask 0, alu_ready 1, mem_ready 1.
REQ-023 SHALL treat rst mid-operation identically; no write issued in cycle following reset edge.

Configuration
REQ-024 SHALL compile pending_mask tracking when WB_PENDING_MASK_EN is defined: bit set for any address in either queue or in the output register with write_en high.
REQ-025 SHALL tie pending_mask to 0 and omit tracking logic when WB_PENDING_MASK_EN is undefined; all other behaviour identical.

Structure
REQ-026 SHALL place in warp_pkg: REG_ADDR_W = 5, XLEN = 32, NUM_REGS = 32, typedef wb_req_t {addr, data}.
REQ-027 SHALL use one sub-module wb_fifo (parameterised depth, wb_req_t payload, push/pop/full/empty), instantiated twice.

Verification
REQ-028 Single: ALU writes R5=0x12345678 in cycle T -> write_en=1, addr=5, data=0x12345678 in T+2 only; register-file readback matches.
REQ-029 Contention: ALU R1=0x11111111 and MEM R2=0x22222222 same cycle after reset -> R1 issued in T+2, R2 in T+3.
REQ-030 Backpressure: FIFO_DEPTH=2, hold alu_valid with MEM saturating, 4 ALU requests -> alu_ready low when 2 queued; all 4 issued in order, none lost.
REQ-031 R0 filter: MEM R0=0xDEADBEEF -> mem_ready 1, write_en never high, R0 reads 0; pending_mask bit 0 stays 0.
REQ-032 Reset mid-flight: queue 3 writes (R3,R4,R5), assert rst before issue -> no write_en after reset, R3-R5 unchanged, readies 1.
REQ-033 Pending mask (WB_PENDING_MASK_EN): queue R7 and R31 -> pending_mask = 0x80000080 until each issues, then 0.

Source files
------------

// File: rtl/warp_pkg.sv
// Shared writeback types and sizes for the register-file writeback path.
package warp_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // One-hot register select, used to build pending-write masks.
  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback queue. Occupancy is tracked with one valid bit per
// slot so full/empty and the pending-address mask fall out directly.
// Optional feature macro: WB_PENDING_MASK_EN (exports addr_mask).
module wb_fifo
  import warp_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  wb_req_t             push_req,
  input  logic                pop,
`ifdef WB_PENDING_MASK_EN
  output logic [NUM_REGS-1:0] addr_mask,
`endif
  output wb_req_t             head,
  output logic                full,
  output logic                empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t          slot_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = &valid_q;
  assign empty   = ~|valid_q;
  assign head    = slot_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointer/valid bookkeeping; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Payload storage; contents are qualified by valid_q so no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      slot_q[wr_ptr_q] <= push_req;
    end
  end

`ifdef WB_PENDING_MASK_EN
  // OR of one-hot addresses of every occupied slot.
  always_comb begin
    addr_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i]) begin
        addr_mask = addr_mask | addr_onehot(slot_q[i].addr);
      end
    end
  end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter merging ALU and load-unit writebacks into the single
// register-file write port. Each source is buffered in its own wb_fifo;
// writes to R0 are accepted and dropped.
// Optional feature macro: WB_PENDING_MASK_EN (enables pending_mask tracking).
module rf_wb_arbiter
  import warp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  mem_ready,
  output logic                  write_en,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]       write_data,
  output logic [NUM_REGS-1:0]   pending_mask
);

  wb_req_t alu_req;
  wb_req_t mem_req;
  wb_req_t alu_head;
  wb_req_t mem_head;
  logic    alu_full;
  logic    mem_full;
  logic    alu_empty;
  logic    mem_empty;
  logic    alu_push;
  logic    mem_push;
  logic    alu_pop;
  logic    mem_pop;
  logic    prefer_mem_q;

`ifdef WB_PENDING_MASK_EN
  logic [NUM_REGS-1:0] alu_mask;
  logic [NUM_REGS-1:0] mem_mask;
`endif

  assign alu_req   = '{addr: alu_addr, data: alu_data};
  assign mem_req   = '{addr: mem_addr, data: mem_data};
  assign alu_ready = ~alu_full;
  assign mem_ready = ~mem_full;
  assign alu_push  = alu_valid & ~alu_full & (alu_addr != '0);
  assign mem_push  = mem_valid & ~mem_full & (mem_addr != '0);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (alu_push),
    .push_req (alu_req),
    .pop      (alu_pop),
`ifdef WB_PENDING_MASK_EN
    .addr_mask(alu_mask),
`endif
    .head     (alu_head),
    .full     (alu_full),
    .empty    (alu_empty)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (mem_push),
    .push_req (mem_req),
    .pop      (mem_pop),
`ifdef WB_PENDING_MASK_EN
    .addr_mask(mem_mask),
`endif
    .head     (mem_head),
    .full     (mem_full),
    .empty    (mem_empty)
  );

  // Grant one head per cycle; on a tie the source not granted last wins.
  always_comb begin
    alu_pop = 1'b0;
    mem_pop = 1'b0;
    if (!alu_empty && (mem_empty || !prefer_mem_q)) begin
      alu_pop = 1'b1;
    end else if (!mem_empty) begin
      mem_pop = 1'b1;
    end
  end

  // Register the granted head onto the write port and advance the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      prefer_mem_q <= 1'b0;
      write_en     <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      write_en <= alu_pop | mem_pop;
      if (alu_pop) begin
        write_addr   <= alu_head.addr;
        write_data   <= alu_head.data;
        prefer_mem_q <= 1'b1;
      end else if (mem_pop) begin
        write_addr   <= mem_head.addr;
        write_data   <= mem_head.data;
        prefer_mem_q <= 1'b0;
      end
    end
  end

`ifdef WB_PENDING_MASK_EN
  // Pending = queued in either source plus the write currently on the port.
  always_comb begin
    pending_mask = alu_mask | mem_mask;
    if (write_en) begin
      pending_mask = pending_mask | addr_onehot(write_addr);
    end
  end
`else
  assign pending_mask = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: single write, contention, backpressure,
// R0 filtering, reset mid-flight and pending-mask tracking.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] pending_mask;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef WB_PENDING_MASK_EN
  localparam bit PM_EN = 1'b1;
`else
  localparam bit PM_EN = 1'b0;
`endif

  logic [31:0] rf [32] = '{default: '0};

  rf_wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .write_en     (write_en),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  // Register-file model fed by the DUT write port.
  always @(posedge clk) begin
    if (write_en) rf[write_addr] <= write_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0]  got_addr [4];
    logic [31:0] got_data [4];
    int          got_cyc  [4];
    int          n_alu;
    int          ai;
    int          mi;
    logic        hs_a;
    logic        hs_m;
    logic        any_we;

    // Reset state
    do_reset();
    check("rst_we",      32'(write_en),   32'd0);
    check("rst_addr",    32'(write_addr), 32'd0);
    check("rst_data",    write_data,      32'd0);
    check("rst_pending", pending_mask,    32'd0);
    check("rst_aready",  32'(alu_ready),  32'd1);
    check("rst_mready",  32'(mem_ready),  32'd1);

    // Single uncontended write: handshake T, write_en only in T+2
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234_5678;
    check("single_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check("single_t1_we", 32'(write_en), 32'd0);
    tick();
    check("single_t2_we",   32'(write_en),   32'd1);
    check("single_t2_addr", 32'(write_addr), 32'd5);
    check("single_t2_data", write_data,      32'h1234_5678);
    tick();
    check("single_t3_we",   32'(write_en),   32'd0);
    check("single_hold_addr", 32'(write_addr), 32'd5);
    check("single_hold_data", write_data,      32'h1234_5678);
    check("single_rf5",     rf[5],           32'h1234_5678);

    // Contention right after reset: ALU wins the first tie
    do_reset();
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1111_1111;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h2222_2222;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("cont_t1_we", 32'(write_en), 32'd0);
    tick();
    check("cont_t2_we",   32'(write_en),   32'd1);
    check("cont_t2_addr", 32'(write_addr), 32'd1);
    check("cont_t2_data", write_data,      32'h1111_1111);
    tick();
    check("cont_t3_we",   32'(write_en),   32'd1);
    check("cont_t3_addr", 32'(write_addr), 32'd2);
    check("cont_t3_data", write_data,      32'h2222_2222);
    tick();
    check("cont_t4_we", 32'(write_en), 32'd0);

    // Backpressure: 4 ALU writes against a saturating MEM stream
    do_reset();
    n_alu = 0; ai = 0; mi = 0;
    for (int c = 0; c < 12; c++) begin
      if (write_en && write_addr >= 5'd10 && write_addr <= 5'd13 && n_alu < 4) begin
        got_addr[n_alu] = write_addr;
        got_data[n_alu] = write_data;
        got_cyc[n_alu]  = c;
        n_alu++;
      end
      if (c == 2) check("bp_c2_aready", 32'(alu_ready), 32'd1);
      if (c == 3) check("bp_c3_aready", 32'(alu_ready), 32'd0);
      if (c == 5) check("bp_c5_aready", 32'(alu_ready), 32'd0);
      alu_valid = (ai < 4);
      alu_addr  = 5'(10 + ai);
      alu_data  = 32'hA000_0000 + 32'(ai);
      mem_valid = 1'b1;
      mem_addr  = 5'(16 + (mi % 8));
      mem_data  = 32'hB000_0000 + 32'(mi);
      hs_a = alu_valid & alu_ready;
      hs_m = mem_valid & mem_ready;
      tick();
      if (hs_a) ai++;
      if (hs_m) mi++;
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("bp_all_accepted", 32'(ai),    32'd4);
    check("bp_alu_issued",   32'(n_alu), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < n_alu) begin
        check($sformatf("bp_addr%0d", k), 32'(got_addr[k]), 32'(10 + k));
        check($sformatf("bp_data%0d", k), got_data[k], 32'hA000_0000 + 32'(k));
        check($sformatf("bp_cyc%0d", k),  32'(got_cyc[k]), 32'(2 + 2 * k));
      end
    end
    for (int k = 0; k < 8; k++) tick();

    // R0 filter: handshake consumed, nothing issued
    do_reset();
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hDEAD_BEEF;
    check("r0_mready", 32'(mem_ready), 32'd1);
    tick();
    mem_valid = 1'b0;
    any_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      any_we |= write_en;
      tick();
    end
    check("r0_no_we",   32'(any_we),  32'd0);
    check("r0_rf0",     rf[0],        32'd0);
    check("r0_pending", pending_mask, 32'd0);

    // Reset while three writes are in flight
    do_reset();
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h0000_0033;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h0000_0044;
    tick();
    alu_addr = 5'd5; alu_data = 32'h0000_0055;
    mem_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; alu_valid = 1'b0;
    check("mid_t0_we", 32'(write_en), 32'd0);
    any_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      any_we |= write_en;
      tick();
    end
    check("mid_no_we",  32'(any_we),    32'd0);
    check("mid_aready", 32'(alu_ready), 32'd1);
    check("mid_mready", 32'(mem_ready), 32'd1);
    check("mid_rf3",    rf[3],          32'd0);
    check("mid_rf4",    rf[4],          32'd0);
    check("mid_rf5",    rf[5],          32'h1234_5678);
    check("mid_pending", pending_mask,  32'd0);

    // Pending mask across queue and write port
    do_reset();
    alu_valid = 1'b1; alu_addr = 5'd7;  alu_data = 32'h0000_0077;
    mem_valid = 1'b1; mem_addr = 5'd31; mem_data = 32'h0000_00FF;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    check("pm_t1", pending_mask, PM_EN ? 32'h8000_0080 : 32'd0);
    tick();
    check("pm_t2", pending_mask, PM_EN ? 32'h8000_0080 : 32'd0);
    check("pm_t2_addr", 32'(write_addr), 32'd7);
    tick();
    check("pm_t3", pending_mask, PM_EN ? 32'h8000_0000 : 32'd0);
    check("pm_t3_addr", 32'(write_addr), 32'd31);
    tick();
    check("pm_t4", pending_mask, 32'd0);
    check("pm_t4_we", 32'(write_en), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
